// File: rtl/fifo_rd_ptr_ctrl.sv
// Read-side pointer controller of an async FIFO: owns the binary/Gray read pointer,
// synchronizes the write Gray pointer into rclk, and derives empty/level/underflow/ack.
module fifo_rd_ptr_ctrl #(
    parameter int ADDRESS_WIDTH = 4,
    parameter int DEPTH         = 16,
    parameter int SYNC_STAGES   = 2,
    parameter int AEMPTY_LEVEL  = 2,
    parameter int STICKY_ERROR  = 0,
    parameter int SOFT_RESET    = 0,
    parameter int PIPE_READ     = 0
) (
    input  logic                     rclk,
    input  logic                     hw_rst_n,
    input  logic                     sw_rst,
    input  logic                     rd_en,
    input  logic [ADDRESS_WIDTH:0]   wptr_gray,
    output logic [ADDRESS_WIDTH:0]   raddr,
    output logic [ADDRESS_WIDTH:0]   rptr_gray,
    output logic                     rd_empty,
    output logic                     rd_almost_empty,
    output logic [ADDRESS_WIDTH:0]   rd_level,
    output logic                     rd_underflow,
    output logic                     rd_ack
);

    localparam int PW        = ADDRESS_WIDTH + 1;
    localparam int ACK_DEPTH = PIPE_READ + 1;
    localparam bit SOFT_EN   = (SOFT_RESET == 1) || (SOFT_RESET == 3);

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    logic [PW-1:0]        wq_q [SYNC_STAGES];
    logic [PW-1:0]        raddr_q, raddr_d;
    logic [PW-1:0]        rgray_q, rgray_d;
    logic                 empty_q, empty_d;
    logic                 aempty_q, aempty_d;
    logic [PW-1:0]        level_q, level_d;
    logic                 uflow_q, uflow_d;
    logic [ACK_DEPTH-1:0] ack_q;

    logic [PW-1:0] wsync;
    logic [PW-1:0] wbin;
    logic          rd_acc;
    logic          soft_clr;

    assign wsync    = wq_q[SYNC_STAGES-1];
    assign wbin     = gray2bin(wsync);
    assign rd_acc   = rd_en & ~empty_q;
    assign soft_clr = SOFT_EN && sw_rst;

    // NOTE: every variable gets a default at the top of always_comb so no latch is inferred.
    always_comb begin
        raddr_d  = raddr_q + {{ADDRESS_WIDTH{1'b0}}, rd_acc};
        rgray_d  = bin2gray(raddr_d);
        empty_d  = (rgray_d == wsync);
        level_d  = wbin - raddr_d;
        aempty_d = (level_d <= PW'(AEMPTY_LEVEL));
        uflow_d  = (rd_en & empty_q) | ((STICKY_ERROR != 0) & uflow_q);
    end

    // NOTE: synchronizer flops are reset too, so a soft or hard reset never resurrects a stale pointer.
    always_ff @(posedge rclk or negedge hw_rst_n) begin
        if (!hw_rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) wq_q[i] <= '0;
        end else if (soft_clr) begin
            for (int i = 0; i < SYNC_STAGES; i++) wq_q[i] <= '0;
        end else begin
            wq_q[0] <= wptr_gray;
            for (int i = 1; i < SYNC_STAGES; i++) wq_q[i] <= wq_q[i-1];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge rclk or negedge hw_rst_n) begin
        if (!hw_rst_n) begin
            raddr_q  <= '0;
            rgray_q  <= '0;
            empty_q  <= 1'b1;
            aempty_q <= 1'b1;
            level_q  <= '0;
            uflow_q  <= 1'b0;
            ack_q    <= '0;
        end else if (soft_clr) begin
            raddr_q  <= '0;
            rgray_q  <= '0;
            empty_q  <= 1'b1;
            aempty_q <= 1'b1;
            level_q  <= '0;
            uflow_q  <= 1'b0;
            ack_q    <= '0;
        end else begin
            raddr_q  <= raddr_d;
            rgray_q  <= rgray_d;
            empty_q  <= empty_d;
            aempty_q <= aempty_d;
            level_q  <= level_d;
            uflow_q  <= uflow_d;
            ack_q[0] <= rd_acc;
            for (int i = 1; i < ACK_DEPTH; i++) ack_q[i] <= ack_q[i-1];
        end
    end

    assign raddr           = raddr_q;
    assign rptr_gray       = rgray_q;
    assign rd_empty        = empty_q;
    assign rd_almost_empty = aempty_q;
    assign rd_level        = level_q;
    assign rd_underflow    = uflow_q;
    assign rd_ack          = ack_q[ACK_DEPTH-1];

endmodule

// File: tb/tb_fifo_rd_ptr_ctrl.sv
// Directed bench for fifo_rd_ptr_ctrl: a vector table plus hand-written reset, soft-reset,
// sticky-underflow and wrap sequences on three differently parameterised instances.
module tb_fifo_rd_ptr_ctrl;

    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          rclk = 1'b0;
    logic          hw_rst_n = 1'b1;
    logic          sw_rst = 1'b0;
    logic          rd_en = 1'b0;
    logic [AW:0]   wptr_gray = '0;

    logic [AW:0] a_raddr, a_rgray, a_level, b_raddr, b_rgray, b_level, c_raddr, c_rgray, c_level;
    logic        a_empty, a_aempty, a_uf, a_ack;
    logic        b_empty, b_aempty, b_uf, b_ack;
    logic        c_empty, c_aempty, c_uf, c_ack;

    int checks = 0;
    int failures = 0;

    // a: pulse underflow, soft reset enabled (3), 1-cycle ack
    fifo_rd_ptr_ctrl #(.ADDRESS_WIDTH(AW), .DEPTH(DEPTH), .SYNC_STAGES(2), .AEMPTY_LEVEL(2),
                       .STICKY_ERROR(0), .SOFT_RESET(3), .PIPE_READ(0)) u_a (
        .rclk(rclk), .hw_rst_n(hw_rst_n), .sw_rst(sw_rst), .rd_en(rd_en), .wptr_gray(wptr_gray),
        .raddr(a_raddr), .rptr_gray(a_rgray), .rd_empty(a_empty), .rd_almost_empty(a_aempty),
        .rd_level(a_level), .rd_underflow(a_uf), .rd_ack(a_ack));

    // b: sticky underflow, soft reset enabled (1), 2-cycle ack
    fifo_rd_ptr_ctrl #(.ADDRESS_WIDTH(AW), .DEPTH(DEPTH), .SYNC_STAGES(2), .AEMPTY_LEVEL(2),
                       .STICKY_ERROR(1), .SOFT_RESET(1), .PIPE_READ(1)) u_b (
        .rclk(rclk), .hw_rst_n(hw_rst_n), .sw_rst(sw_rst), .rd_en(rd_en), .wptr_gray(wptr_gray),
        .raddr(b_raddr), .rptr_gray(b_rgray), .rd_empty(b_empty), .rd_almost_empty(b_aempty),
        .rd_level(b_level), .rd_underflow(b_uf), .rd_ack(b_ack));

    // c: soft reset disabled (2)
    fifo_rd_ptr_ctrl #(.ADDRESS_WIDTH(AW), .DEPTH(DEPTH), .SYNC_STAGES(2), .AEMPTY_LEVEL(2),
                       .STICKY_ERROR(0), .SOFT_RESET(2), .PIPE_READ(0)) u_c (
        .rclk(rclk), .hw_rst_n(hw_rst_n), .sw_rst(sw_rst), .rd_en(rd_en), .wptr_gray(wptr_gray),
        .raddr(c_raddr), .rptr_gray(c_rgray), .rd_empty(c_empty), .rd_almost_empty(c_aempty),
        .rd_level(c_level), .rd_underflow(c_uf), .rd_ack(c_ack));

    always #5 rclk = ~rclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge rclk);
        #1;
    endtask

    // Occupancy beyond DEPTH means a corrupt write pointer; a and b never see one here.
    always @(negedge rclk) begin
        if (hw_rst_n && (a_level > DEPTH || b_level > DEPTH)) begin
            failures++;
            $display("FAIL occupancy_bound: a=%0d b=%0d limit=%0d", a_level, b_level, DEPTH);
        end
    end

    typedef struct {
        logic        rd_en;
        logic [AW:0] wptr;
        logic [AW:0] raddr;
        logic [AW:0] rgray;
        logic        empty;
        logic        aempty;
        logic [AW:0] level;
        logic        uf;
        logic        ack;
    } vec_t;

    vec_t vecs[21];

    task automatic check_reset_a(input string tag);
        check({tag, "_raddr"},  a_raddr, 0);
        check({tag, "_rgray"},  a_rgray, 0);
        check({tag, "_empty"},  a_empty, 1);
        check({tag, "_aempty"}, a_aempty, 1);
        check({tag, "_level"},  a_level, 0);
        check({tag, "_uf"},     a_uf, 0);
        check({tag, "_ack"},    a_ack, 0);
    endtask

    initial begin
        logic prev_ack;
        logic sticky_seen;

        // rd_en, wptr, raddr, rgray, empty, aempty, level, uf, ack (values after the edge)
        vecs[0]  = '{1'b0, 5'h01, 5'd0, 5'h00, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 5'h01, 5'd0, 5'h00, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 5'h01, 5'd0, 5'h00, 1'b0, 1'b1, 5'd1, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 5'h01, 5'd1, 5'h01, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1};
        vecs[4]  = '{1'b0, 5'h01, 5'd1, 5'h01, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 5'h06, 5'd1, 5'h01, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 5'h06, 5'd1, 5'h01, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 5'h06, 5'd1, 5'h01, 1'b0, 1'b0, 5'd3, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 5'h06, 5'd2, 5'h03, 1'b0, 1'b1, 5'd2, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 5'h05, 5'd2, 5'h03, 1'b0, 1'b1, 5'd2, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 5'h05, 5'd2, 5'h03, 1'b0, 1'b1, 5'd2, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 5'h05, 5'd2, 5'h03, 1'b0, 1'b0, 5'd4, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 5'h05, 5'd3, 5'h02, 1'b0, 1'b0, 5'd3, 1'b0, 1'b1};
        vecs[13] = '{1'b1, 5'h05, 5'd4, 5'h06, 1'b0, 1'b1, 5'd2, 1'b0, 1'b1};
        vecs[14] = '{1'b1, 5'h05, 5'd5, 5'h07, 1'b0, 1'b1, 5'd1, 1'b0, 1'b1};
        vecs[15] = '{1'b1, 5'h05, 5'd6, 5'h05, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1};
        vecs[16] = '{1'b1, 5'h05, 5'd6, 5'h05, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0};
        vecs[17] = '{1'b1, 5'h05, 5'd6, 5'h05, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0};
        vecs[18] = '{1'b1, 5'h05, 5'd6, 5'h05, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0};
        vecs[19] = '{1'b0, 5'h05, 5'd6, 5'h05, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0};
        vecs[20] = '{1'b0, 5'h05, 5'd6, 5'h05, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0};

        // Power-on hard reset, checked asynchronously before any clock edge.
        #2 hw_rst_n = 1'b0;
        #1 check_reset_a("por");
        step();
        step();
        hw_rst_n = 1'b1;

        // Vector table: latency, single entry, almost-empty, drain, underflow.
        prev_ack    = 1'b0;
        sticky_seen = 1'b0;
        for (int i = 0; i < 21; i++) begin
            rd_en     = vecs[i].rd_en;
            wptr_gray = vecs[i].wptr;
            step();
            check($sformatf("v%0d_raddr", i),  a_raddr,  vecs[i].raddr);
            check($sformatf("v%0d_rgray", i),  a_rgray,  vecs[i].rgray);
            check($sformatf("v%0d_empty", i),  a_empty,  vecs[i].empty);
            check($sformatf("v%0d_aempty", i), a_aempty, vecs[i].aempty);
            check($sformatf("v%0d_level", i),  a_level,  vecs[i].level);
            check($sformatf("v%0d_uf", i),     a_uf,     vecs[i].uf);
            check($sformatf("v%0d_ack", i),    a_ack,    vecs[i].ack);
            sticky_seen = sticky_seen | vecs[i].uf;
            check($sformatf("v%0d_b_ack", i),  b_ack,    prev_ack);
            check($sformatf("v%0d_b_uf", i),   b_uf,     sticky_seen);
            check($sformatf("v%0d_c_raddr", i), c_raddr, vecs[i].raddr);
            prev_ack = vecs[i].ack;
        end

        // Soft reset with rd_en low: clears a and b (including sticky underflow), c ignores it.
        sw_rst    = 1'b1;
        wptr_gray = 5'h00;
        step();
        sw_rst = 1'b0;
        check_reset_a("sw1");
        check("sw1_b_raddr", b_raddr, 0);
        check("sw1_b_uf",    b_uf, 0);
        check("sw1_c_raddr", c_raddr, 6);

        // Hard reset asserted mid-read at raddr=5.
        wptr_gray = 5'b01100;  // gray(8)
        repeat (3) step();
        check("hr_fill_level", a_level, 8);
        rd_en = 1'b1;
        repeat (5) step();
        check("hr_pre_raddr", a_raddr, 5);
        #3 hw_rst_n = 1'b0;
        #1 check_reset_a("hr_async");
        check("hr_b_raddr", b_raddr, 0);
        step();
        check("hr_hold_raddr", a_raddr, 0);
        rd_en    = 1'b0;
        hw_rst_n = 1'b1;

        // Soft reset with rd_en at level=5, raddr=7.
        wptr_gray = 5'b01010;  // gray(12)
        repeat (3) step();
        rd_en = 1'b1;
        repeat (7) step();
        check("sr_pre_raddr", a_raddr, 7);
        check("sr_pre_level", a_level, 5);
        sw_rst    = 1'b1;
        wptr_gray = 5'h00;
        step();
        sw_rst = 1'b0;
        rd_en  = 1'b0;
        check("sr_raddr", a_raddr, 0);
        check("sr_empty", a_empty, 1);
        check("sr_level", a_level, 0);
        check("sr_b_raddr", b_raddr, 0);
        check("sr_c_raddr", c_raddr, 8);
        check("sr_c_level", c_level, 4);
        hw_rst_n = 1'b0;
        step();
        hw_rst_n = 1'b1;

        // Full FIFO and pointer wrap.
        wptr_gray = 5'b11000;  // gray(16)
        repeat (3) step();
        check("full_level",  a_level, 16);
        check("full_empty",  a_empty, 0);
        check("full_aempty", a_aempty, 0);
        rd_en = 1'b1;
        repeat (16) step();
        rd_en = 1'b0;
        check("drain1_raddr", a_raddr, 5'b10000);
        check("drain1_rgray", a_rgray, 5'b11000);
        check("drain1_empty", a_empty, 1);
        check("drain1_level", a_level, 0);
        wptr_gray = 5'b00000;  // gray(32 mod 32)
        repeat (3) step();
        check("full2_level", a_level, 16);
        rd_en = 1'b1;
        repeat (15) step();
        check("wrap_pre_raddr", a_raddr, 31);
        check("wrap_pre_rgray", a_rgray, 5'b10000);
        step();
        rd_en = 1'b0;
        check("wrap_raddr", a_raddr, 0);
        check("wrap_rgray", a_rgray, 0);
        check("wrap_empty", a_empty, 1);
        check("wrap_b_ack", b_ack, 1);
        step();
        check("wrap_post_ack", a_ack, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
